// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bundle for fetch_unit
//
// Signals:
//   imem_req   : fetch request, driven by the fetch stage
//   imem_addr  : byte address of the fetch, driven by the fetch stage
//   imem_rdata : instruction word, driven by memory, valid with imem_ready
//   imem_ready : memory accepts the request and returns data this cycle
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, next-PC select
//
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   imem                : fetch_unit_if.master (imem_req/imem_addr out, imem_rdata/imem_ready in)
//   advance             : datapath finished the held instruction
//   branch, bne, jump, jr, zero, jr_target : control/ALU inputs for next-PC selection
//   instr, instr_valid, opcode, func       : held instruction and its decode slices
//   pc, pc_plus4        : address of the held instruction and its link value
//   retired_count       : instructions advanced since reset (CNT_W bits, wraps)
//   fetch_fault         : misaligned-target trap, present only with FETCH_ALIGN_CHECK_EN
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When undefined, next-PC bits [1:0]
// are cleared before loading pc; when defined, a misaligned target traps into FAULT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    fetch_unit_if.master      imem,
    input  logic              advance,
    input  logic              branch,
    input  logic              bne,
    input  logic              jump,
    input  logic              jr,
    input  logic              zero,
    input  logic [31:0]       jr_target,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              fetch_fault,
`endif
    output logic [CNT_W-1:0]  retired_count
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {BOOT, REQ, HOLD, FAULT} state_t;
`else
    typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;
`endif

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             instr_valid_q;
    logic             imem_req_q;
    logic [CNT_W-1:0] retired_q;
    logic [31:0]      pc_plus4_w;
    logic [31:0]      next_pc_d;
    logic [31:0]      pc_load_d;
`ifdef FETCH_ALIGN_CHECK_EN
    logic             fault_q;
    logic             misaligned_w;
`endif

    assign pc_plus4_w = pc_q + 32'd4;

    // Priority jr > jump > taken branch > sequential. bne inverts the zero test.
    always_comb begin
        next_pc_d = pc_plus4_w;
        if (jr) begin
            next_pc_d = jr_target;
        end else if (jump) begin
            next_pc_d = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
        end else if (branch && (zero ^ bne)) begin
            next_pc_d = pc_plus4_w + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned_w = (next_pc_d[1:0] != 2'b00);
    assign pc_load_d    = next_pc_d;
`else
    // Only jr can produce low bits; the fetch address is kept word aligned.
    assign pc_load_d    = next_pc_d & ~32'h3;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            retired_q     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    // Request and address stay put until memory responds.
                    if (imem.imem_ready) begin
                        instr_q       <= imem.imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned_w) begin
                            // Trap: pc, instr and count freeze; only reset leaves.
                            state_q       <= FAULT;
                            fault_q       <= 1'b1;
                            instr_valid_q <= 1'b0;
                        end else begin
                            pc_q          <= pc_load_d;
                            instr_valid_q <= 1'b0;
                            retired_q     <= retired_q + CNT_W'(1);
                            imem_req_q    <= 1'b1;
                            state_q       <= REQ;
                        end
`else
                        pc_q          <= pc_load_d;
                        instr_valid_q <= 1'b0;
                        retired_q     <= retired_q + CNT_W'(1);
                        imem_req_q    <= 1'b1;
                        state_q       <= REQ;
`endif
                    end
                end
`ifdef FETCH_ALIGN_CHECK_EN
                FAULT: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q    <= BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign opcode         = instr_q[31:26];
    assign func           = instr_q[5:0];
    assign pc             = pc_q;
    assign pc_plus4       = pc_plus4_w;
    assign retired_count  = retired_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault    = fault_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Holds the PC and fetches from instruction memory over a req/ready handshake.
- Presents the held instruction plus the opcode/func slices to control.
- Computes the next PC from the control outputs branch/bne/jump/jr, the ALU zero flag and the jr register value, then advances when the datapath signals completion.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  byte address of the fetch; equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory accepts the request and returns data this cycle.
- advance  in  1  datapath finished the current instruction.
- branch  in  1  from control.
- bne  in  1  from control.
- jump  in  1  from control.
- jr  in  1  from control.
- zero  in  1  ALU zero flag.
- jr_target  in  32  rs register value for jr.
- instr  out  32  held instruction.
- instr_valid  out  1  instr/opcode/func are valid.
- opcode  out  6  instr[31:26].
- func  out  6  instr[5:0].
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4 (jal link value).
- retired_count  out  CNT_W  instructions advanced since reset.
- fetch_fault  out  1  misaligned target trap; exists only with the optional feature.

Behaviour:
- Reset is synchronous, active-high, and applies on any clock edge, including mid-fetch. It sets:
  - pc=RESET_PC, state=BOOT
  - instr=0, instr_valid=0, imem_req=0
  - retired_count=0, fetch_fault=0
- State BOOT: imem_req=0. Moves to REQ on the next cycle (one idle cycle after reset release).
- State REQ:
  - imem_req=1, imem_addr=pc.
  - While imem_ready=0: hold the request, keep imem_addr stable, no limit on wait length.
  - On imem_ready=1: latch instr<=imem_rdata, instr_valid<=1, go to HOLD. Fetch latency is therefore at least 1 cycle from request to instr_valid.
- State HOLD:
  - imem_req=0; instr, pc, instr_valid=1 held stable.
  - On advance=1: pc<=next_pc, instr_valid<=0, retired_count<=retired_count+1, go to REQ.
  - advance is ignored in BOOT and REQ.
- Outputs opcode, func and pc_plus4 are combinational from instr/pc and are always driven, even when instr_valid=0.
- next_pc is combinational. Priority jr > jump > branch-taken > sequential:
  - jr=1 -> jr_target.
  - jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch=1 and (zero XOR bne)=1 -> pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else -> pc_plus4.
- Arithmetic is 32-bit modulo 2^32; PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- retired_count wraps to 0 at 2^CNT_W.
- Simultaneous branch=1 and jump=1 resolves as jump. jr=1 overrides both.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - When advance=1 and next_pc[1:0]!=0: go to FAULT and set fetch_fault=1.
  - pc, instr and retired_count do not update.
  - FAULT asserts imem_req=0 and instr_valid=0 and is left only by reset.
- Not defined:
  - No fetch_fault port.
  - next_pc[1:0] is forced to 2'b00 before loading pc.

Test Plan:
- Reset release with RESET_PC=0, imem_ready tied 1:
  - imem_req rises 1 cycle after reset deasserts with imem_addr=0.
  - instr_valid=1 on the next cycle.
  - opcode/func match imem_rdata=32'h0000_0020.
- imem_ready held 0 for 5 cycles:
  - imem_req stays 1 and imem_addr stays constant.
  - instr_valid=0 throughout; it rises one cycle after imem_ready.
- Sequential advance from pc=32'h10 with all control inputs 0:
  - Next imem_addr=32'h14.
  - retired_count increments by 1.
- Branch at pc=32'h20, instr[15:0]=16'hFFFE:
  - branch=1, zero=1, bne=0 -> next pc=32'h1C.
  - branch=1, bne=1, zero=1 -> next pc=32'h24.
- Jump and jr priority:
  - jump=1, instr[25:0]=26'h40, pc=32'h1000_0000 -> next pc=32'h1000_0100.
  - jr=1, jump=1, jr_target=32'h88 -> next pc=32'h88.
- Reset asserted in REQ while imem_ready=0:
  - Next cycle: pc=RESET_PC, instr_valid=0, imem_req=0, retired_count=0.
  - With FETCH_ALIGN_CHECK_EN defined, jr_target=32'h6 -> fetch_fault=1, pc unchanged.
